// File: rtl/vmcs_table_if.sv
// vmcs_table_if: hypervisor-side request/status bundle for vmcs_table.
// entry_timer_i is present only when VMCS_PREEMPT_TIMER_EN is defined.
interface vmcs_table_if #(
  parameter int NUM_VMS  = 4,
  parameter int VMID_W   = 8,
  parameter int REASON_W = 4
`ifdef VMCS_PREEMPT_TIMER_EN
  , parameter int TIMER_W = 16
`endif
);
  localparam int SLOT_W = $clog2(NUM_VMS);

  logic                alloc_valid_i;
  logic [VMID_W-1:0]   alloc_vmid_i;
  logic                alloc_ready_o;
  logic [SLOT_W-1:0]   alloc_slot_o;
  logic                free_valid_i;
  logic [SLOT_W-1:0]   free_slot_i;
  logic                entry_valid_i;
  logic [SLOT_W-1:0]   entry_slot_i;
  logic                entry_ready_o;
  logic                exit_valid_i;
  logic [REASON_W-1:0] exit_reason_i;
  logic                running_o;
  logic [VMID_W-1:0]   current_vmid_o;
  logic [SLOT_W-1:0]   current_slot_o;
  logic                exit_pulse_o;
  logic [REASON_W-1:0] last_exit_reason_o;
  logic [SLOT_W:0]     active_cnt_o;
  logic                err_o;
`ifdef VMCS_PREEMPT_TIMER_EN
  logic [TIMER_W-1:0]  entry_timer_i;
`endif

  modport master (
`ifdef VMCS_PREEMPT_TIMER_EN
    output entry_timer_i,
`endif
    output alloc_valid_i, alloc_vmid_i, free_valid_i, free_slot_i,
    output entry_valid_i, entry_slot_i, exit_valid_i, exit_reason_i,
    input  alloc_ready_o, alloc_slot_o, entry_ready_o, running_o,
    input  current_vmid_o, current_slot_o, exit_pulse_o, last_exit_reason_o,
    input  active_cnt_o, err_o
  );

  modport slave (
`ifdef VMCS_PREEMPT_TIMER_EN
    input  entry_timer_i,
`endif
    input  alloc_valid_i, alloc_vmid_i, free_valid_i, free_slot_i,
    input  entry_valid_i, entry_slot_i, exit_valid_i, exit_reason_i,
    output alloc_ready_o, alloc_slot_o, entry_ready_o, running_o,
    output current_vmid_o, current_slot_o, exit_pulse_o, last_exit_reason_o,
    output active_cnt_o, err_o
  );
endinterface

// File: rtl/vmcs_table.sv
// vmcs_table: multi-context VM control table with entry/exit sequencing FSM.
// Optional preemption timer enabled by defining VMCS_PREEMPT_TIMER_EN.
//   state   | meaning
//   S_IDLE  | no guest; accepts entry handshake
//   S_ENTER | one-cycle entry, timer load
//   S_GUEST | guest running, current_vmid_o valid
//   S_EXIT  | one-cycle exit pulse, slot returns to READY
module vmcs_table #(
  parameter int NUM_VMS  = 4,
  parameter int VMID_W   = 8,
  parameter int REASON_W = 4
`ifdef VMCS_PREEMPT_TIMER_EN
  , parameter int TIMER_W = 16
`endif
) (
  input logic         clk,
  input logic         rst_n,
  vmcs_table_if.slave bus
);
  localparam int SLOT_W = $clog2(NUM_VMS);

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_GUEST, S_EXIT} fsm_t;
  typedef enum logic [1:0] {SL_FREE, SL_READY, SL_RUNNING} slot_t;

  fsm_t                state_q, state_d;
  slot_t               slot_st_q   [NUM_VMS];
  logic [VMID_W-1:0]   slot_vmid_q [NUM_VMS];
  logic [SLOT_W-1:0]   cur_slot_q;
  logic [REASON_W-1:0] last_reason_q, reason_d;
  logic [SLOT_W:0]     active_cnt_q;
  logic                err_q;

  logic                any_free;
  logic [SLOT_W-1:0]   low_free;
  logic                vmid_dup;
  logic [SLOT_W:0]     busy_cnt;
  logic                entry_hs, entry_ok, alloc_ok, free_ok, any_err;
  logic                tmr_expire;

  always_comb begin
    any_free = 1'b0;
    low_free = '0;
    vmid_dup = 1'b0;
    busy_cnt = '0;
    for (int i = NUM_VMS - 1; i >= 0; i--) begin
      if (slot_st_q[i] == SL_FREE) begin
        any_free = 1'b1;
        low_free = SLOT_W'(i);
      end else begin
        busy_cnt = busy_cnt + (SLOT_W + 1)'(1);
        if (slot_vmid_q[i] == bus.alloc_vmid_i) vmid_dup = 1'b1;
      end
    end
  end

  // A free aimed at the slot being entered this cycle loses to the entry.
  assign entry_hs = bus.entry_valid_i && (state_q == S_IDLE);
  assign entry_ok = entry_hs && (slot_st_q[bus.entry_slot_i] == SL_READY);
  assign alloc_ok = bus.alloc_valid_i && any_free && (bus.alloc_vmid_i != '0) && !vmid_dup;
  assign free_ok  = bus.free_valid_i && (slot_st_q[bus.free_slot_i] == SL_READY) &&
                    !(entry_ok && (bus.entry_slot_i == bus.free_slot_i));
  assign any_err  = (bus.alloc_valid_i && !alloc_ok) ||
                    (bus.free_valid_i  && !free_ok)  ||
                    (entry_hs          && !entry_ok) ||
                    (bus.exit_valid_i  && (state_q != S_GUEST));

`ifdef VMCS_PREEMPT_TIMER_EN
  logic [TIMER_W-1:0] tmr_load_q, tmr_q;

  // A load value of 0 never reaches the terminal count of 1, so it disables expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_load_q <= '0;
      tmr_q      <= '0;
    end else begin
      if (entry_ok) tmr_load_q <= bus.entry_timer_i;
      if (state_q == S_ENTER) tmr_q <= tmr_load_q;
      else if (state_q == S_GUEST && tmr_q != '0) tmr_q <= tmr_q - TIMER_W'(1);
    end
  end

  assign tmr_expire = (state_q == S_GUEST) && (tmr_q == TIMER_W'(1));
`else
  assign tmr_expire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    reason_d = last_reason_q;
    unique case (state_q)
      S_IDLE:  if (entry_ok) state_d = S_ENTER;
      S_ENTER: state_d = S_GUEST;
      S_GUEST: begin
        if (bus.exit_valid_i) begin
          state_d  = S_EXIT;
          reason_d = bus.exit_reason_i;
        end else if (tmr_expire) begin
          state_d  = S_EXIT;
          reason_d = '1;
        end
      end
      S_EXIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cur_slot_q    <= '0;
      last_reason_q <= '0;
      active_cnt_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_reason_q <= reason_d;
      active_cnt_q  <= busy_cnt;
      err_q         <= any_err;
      if (entry_ok) cur_slot_q <= bus.entry_slot_i;
    end
  end

  // Alloc targets FREE, free/entry target READY, exit targets RUNNING: no overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VMS; i++) begin
        slot_st_q[i]   <= SL_FREE;
        slot_vmid_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VMS; i++) begin
        if (alloc_ok && low_free == SLOT_W'(i)) begin
          slot_st_q[i]   <= SL_READY;
          slot_vmid_q[i] <= bus.alloc_vmid_i;
        end
        if (free_ok && bus.free_slot_i == SLOT_W'(i)) slot_st_q[i] <= SL_FREE;
        if (entry_ok && bus.entry_slot_i == SLOT_W'(i)) slot_st_q[i] <= SL_RUNNING;
        if (state_q == S_EXIT && cur_slot_q == SLOT_W'(i)) slot_st_q[i] <= SL_READY;
      end
    end
  end

  assign bus.alloc_ready_o      = any_free;
  assign bus.alloc_slot_o       = low_free;
  assign bus.entry_ready_o      = (state_q == S_IDLE);
  assign bus.running_o          = (state_q == S_GUEST);
  assign bus.current_vmid_o     = (state_q == S_GUEST) ? slot_vmid_q[cur_slot_q] : '0;
  assign bus.current_slot_o     = (state_q == S_IDLE) ? '0 : cur_slot_q;
  assign bus.exit_pulse_o       = (state_q == S_EXIT);
  assign bus.last_exit_reason_o = last_reason_q;
  assign bus.active_cnt_o       = active_cnt_q;
  assign bus.err_o              = err_q;
endmodule

// File: tb/tb_vmcs_table.sv
// tb_vmcs_table: table-driven directed bench for vmcs_table (NUM_VMS=4, VMID_W=8, REASON_W=4).
// Timer vectors are added when VMCS_PREEMPT_TIMER_EN is defined.
module tb_vmcs_table;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vmcs_table_if bus ();
  vmcs_table dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic av; logic [7:0] avmid; logic fv; logic [1:0] fslot;
    logic ev; logic [1:0] eslot; logic xv; logic [3:0] xr; logic [15:0] tmr;
  } stim_t;

  typedef struct packed {
    logic ar; logic [1:0] as; logic er; logic run; logic [7:0] vmid;
    logic [1:0] cs; logic xp; logic [3:0] rsn; logic [2:0] cnt; logic err;
  } obs_t;

  typedef struct {
    string name;
    stim_t s;
    obs_t  e;
  } vec_t;

  vec_t tab[$];
  int   errors = 0;
  int   checks = 0;

  function automatic stim_t st(int av, int avmid, int fv, int fslot, int ev, int eslot,
                               int xv, int xr, int tmr = 0);
    stim_t s;
    s.av = 1'(av); s.avmid = 8'(avmid); s.fv = 1'(fv); s.fslot = 2'(fslot);
    s.ev = 1'(ev); s.eslot = 2'(eslot); s.xv = 1'(xv); s.xr = 4'(xr); s.tmr = 16'(tmr);
    return s;
  endfunction

  function automatic obs_t ob(int ar, int as, int er, int run, int vmid, int cs,
                              int xp, int rsn, int cnt, int err);
    obs_t o;
    o.ar = 1'(ar); o.as = 2'(as); o.er = 1'(er); o.run = 1'(run); o.vmid = 8'(vmid);
    o.cs = 2'(cs); o.xp = 1'(xp); o.rsn = 4'(rsn); o.cnt = 3'(cnt); o.err = 1'(err);
    return o;
  endfunction

  task automatic add(string n, stim_t s, obs_t e);
    tab.push_back('{n, s, e});
  endtask

  task automatic drive(stim_t s);
    bus.alloc_valid_i = s.av;  bus.alloc_vmid_i  = s.avmid;
    bus.free_valid_i  = s.fv;  bus.free_slot_i   = s.fslot;
    bus.entry_valid_i = s.ev;  bus.entry_slot_i  = s.eslot;
    bus.exit_valid_i  = s.xv;  bus.exit_reason_i = s.xr;
`ifdef VMCS_PREEMPT_TIMER_EN
    bus.entry_timer_i = s.tmr;
`endif
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.ar = bus.alloc_ready_o;   o.as = bus.alloc_slot_o;   o.er = bus.entry_ready_o;
    o.run = bus.running_o;      o.vmid = bus.current_vmid_o; o.cs = bus.current_slot_o;
    o.xp = bus.exit_pulse_o;    o.rsn = bus.last_exit_reason_o;
    o.cnt = bus.active_cnt_o;   o.err = bus.err_o;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("ar=%0b as=%0d er=%0b run=%0b vmid=%0d cs=%0d xp=%0b rsn=%0h cnt=%0d err=%0b",
                     o.ar, o.as, o.er, o.run, o.vmid, o.cs, o.xp, o.rsn, o.cnt, o.err);
  endfunction

  task automatic check(string n, obs_t exp);
    obs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual {%s} required {%s}", n, fmt(act), fmt(exp));
    end
  endtask

  task automatic run_vec(vec_t v);
    @(negedge clk);
    drive(v.s);
    @(posedge clk);
    #1;
    check(v.name, v.e);
  endtask

  obs_t rst_obs;

  initial begin
    rst_obs = ob(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    drive(st(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", rst_obs);
    @(negedge clk);
    rst_n = 1'b1;

    //           name              av vmid fv fs ev es xv xr         ar as er run vmid cs xp rsn cnt err
    add("alloc5",          st(1, 5, 0, 0, 0, 0, 0, 0),  ob(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    add("alloc5_dup",      st(1, 5, 0, 0, 0, 0, 0, 0),  ob(1, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    add("alloc_vmid0",     st(1, 0, 0, 0, 0, 0, 0, 0),  ob(1, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    add("idle_a",          st(0, 0, 0, 0, 0, 0, 0, 0),  ob(1, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    add("entry0_enter",    st(0, 0, 0, 0, 1, 0, 0, 0),  ob(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    add("entry0_guest",    st(0, 0, 0, 0, 0, 0, 0, 0),  ob(1, 1, 0, 1, 5, 0, 0, 0, 1, 0));
    add("exit3_pulse",     st(0, 0, 0, 0, 0, 0, 1, 3),  ob(1, 1, 0, 0, 0, 0, 1, 3, 1, 0));
    add("exit3_idle",      st(0, 0, 0, 0, 0, 0, 0, 0),  ob(1, 1, 1, 0, 0, 0, 0, 3, 1, 0));
    add("exit_in_idle",    st(0, 0, 0, 0, 0, 0, 1, 7),  ob(1, 1, 1, 0, 0, 0, 0, 3, 1, 1));
    add("entry_free_slot", st(0, 0, 0, 0, 1, 1, 0, 0),  ob(1, 1, 1, 0, 0, 0, 0, 3, 1, 1));
    add("alloc6",          st(1, 6, 0, 0, 0, 0, 0, 0),  ob(1, 2, 1, 0, 0, 0, 0, 3, 1, 0));
    add("alloc7",          st(1, 7, 0, 0, 0, 0, 0, 0),  ob(1, 3, 1, 0, 0, 0, 0, 3, 2, 0));
    add("alloc8_full",     st(1, 8, 0, 0, 0, 0, 0, 0),  ob(0, 0, 1, 0, 0, 0, 0, 3, 3, 0));
    add("alloc9_nofree",   st(1, 9, 0, 0, 0, 0, 0, 0),  ob(0, 0, 1, 0, 0, 0, 0, 3, 4, 1));
    add("free2_alloc_rej", st(1, 10, 1, 2, 0, 0, 0, 0), ob(1, 2, 1, 0, 0, 0, 0, 3, 4, 1));
    add("alloc10_slot2",   st(1, 10, 0, 0, 0, 0, 0, 0), ob(0, 0, 1, 0, 0, 0, 0, 3, 3, 0));
    add("idle_b",          st(0, 0, 0, 0, 0, 0, 0, 0),  ob(0, 0, 1, 0, 0, 0, 0, 3, 4, 0));
    add("entry1_enter",    st(0, 0, 0, 0, 1, 1, 0, 0),  ob(0, 0, 0, 0, 0, 1, 0, 3, 4, 0));
    add("entry1_guest",    st(0, 0, 0, 0, 0, 0, 0, 0),  ob(0, 0, 0, 1, 6, 1, 0, 3, 4, 0));
    add("free_running",    st(0, 0, 1, 1, 0, 0, 0, 0),  ob(0, 0, 0, 1, 6, 1, 0, 3, 4, 1));
    add("exit9_pulse",     st(0, 0, 0, 0, 0, 0, 1, 9),  ob(0, 0, 0, 0, 0, 1, 1, 9, 4, 0));
    add("exit9_idle",      st(0, 0, 0, 0, 0, 0, 0, 0),  ob(0, 0, 1, 0, 0, 0, 0, 9, 4, 0));
    add("free1_ready",     st(0, 0, 1, 1, 0, 0, 0, 0),  ob(1, 1, 1, 0, 0, 0, 0, 9, 4, 0));
    add("idle_c",          st(0, 0, 0, 0, 0, 0, 0, 0),  ob(1, 1, 1, 0, 0, 0, 0, 9, 3, 0));
    add("entry0_again",    st(0, 0, 0, 0, 1, 0, 0, 0),  ob(1, 1, 0, 0, 0, 0, 0, 9, 3, 0));
    add("exit_in_enter",   st(0, 0, 0, 0, 0, 0, 1, 5),  ob(1, 1, 0, 1, 5, 0, 0, 9, 3, 1));
    add("guest_hold",      st(0, 0, 0, 0, 0, 0, 0, 0),  ob(1, 1, 0, 1, 5, 0, 0, 9, 3, 0));

    foreach (tab[i]) run_vec(tab[i]);

    // Asynchronous reset while a guest is running.
    @(negedge clk);
    drive(st(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    check("rst_async_guest", rst_obs);
    @(posedge clk);
    #1;
    check("rst_held_no_pulse", rst_obs);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_released", rst_obs);
    run_vec('{"alloc5_after_rst", st(1, 5, 0, 0, 0, 0, 0, 0), ob(1, 1, 1, 0, 0, 0, 0, 0, 0, 0)});

`ifdef VMCS_PREEMPT_TIMER_EN
    tab.delete();
    add("t_idle",          st(0, 0, 0, 0, 0, 0, 0, 0),    ob(1, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    add("t_entry3",        st(0, 0, 0, 0, 1, 0, 0, 0, 3), ob(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    add("t_guest1",        st(0, 0, 0, 0, 0, 0, 0, 0),    ob(1, 1, 0, 1, 5, 0, 0, 0, 1, 0));
    add("t_guest2",        st(0, 0, 0, 0, 0, 0, 0, 0),    ob(1, 1, 0, 1, 5, 0, 0, 0, 1, 0));
    add("t_guest3",        st(0, 0, 0, 0, 0, 0, 0, 0),    ob(1, 1, 0, 1, 5, 0, 0, 0, 1, 0));
    add("t_expire_exit",   st(0, 0, 0, 0, 0, 0, 0, 0),    ob(1, 1, 0, 0, 0, 0, 1, 15, 1, 0));
    add("t_expire_idle",   st(0, 0, 0, 0, 0, 0, 0, 0),    ob(1, 1, 1, 0, 0, 0, 0, 15, 1, 0));
    add("t2_entry3",       st(0, 0, 0, 0, 1, 0, 0, 0, 3), ob(1, 1, 0, 0, 0, 0, 0, 15, 1, 0));
    add("t2_guest1",       st(0, 0, 0, 0, 0, 0, 0, 0),    ob(1, 1, 0, 1, 5, 0, 0, 15, 1, 0));
    add("t2_guest2",       st(0, 0, 0, 0, 0, 0, 0, 0),    ob(1, 1, 0, 1, 5, 0, 0, 15, 1, 0));
    add("t2_guest3",       st(0, 0, 0, 0, 0, 0, 0, 0),    ob(1, 1, 0, 1, 5, 0, 0, 15, 1, 0));
    add("t2_ext_wins",     st(0, 0, 0, 0, 0, 0, 1, 2),    ob(1, 1, 0, 0, 0, 0, 1, 2, 1, 0));
    add("t2_idle",         st(0, 0, 0, 0, 0, 0, 0, 0),    ob(1, 1, 1, 0, 0, 0, 0, 2, 1, 0));
    foreach (tab[i]) run_vec(tab[i]);
`endif

    @(negedge clk);
    drive(st(0, 0, 0, 0, 0, 0, 0, 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
